apb_mem_ctrl: RTL and testbench
===============================

// Module: apb_mem_ctrl
// PURPOSE
//  APB3 slave that sequences a single-port synchronous RAM (1-cycle registered read, write on clock edge).
//  Decodes/validates PADDR, issues single-cycle memory strobes, inserts the wait states the RAM needs.
//  Sits between the APB interconnect and the Memory_model instance; sole owner of the RAM port.
// PARAMETERS
//  APB_ADDR_WIDTH  32  PADDR width (byte address)
//  ADDR_WIDTH      16  RAM word-address width; depth = 2^ADDR_WIDTH
//  DATA_WIDTH      32  PWDATA/PRDATA/RAM word width; multiple of 8; OFS = log2(DATA_WIDTH/8)
// PORTS
//  i_clk        in   1               clock, all logic on rising edge
//  i_rst        in   1               reset, asynchronous, active-high
//  i_psel       in   1               APB select
//  i_penable    in   1               APB access phase
//  i_pwrite     in   1               1 write, 0 read
//  i_paddr      in   APB_ADDR_WIDTH  byte address
//  i_pwdata     in   DATA_WIDTH      write data
//  i_pstrb      in   DATA_WIDTH/8    byte strobes (present only with APB_MEM_PSTRB_EN)
//  o_prdata     out  DATA_WIDTH      read data
//  o_pready     out  1               transfer complete
//  o_pslverr    out  1               transfer error
//  o_mem_en     out  1               RAM enable (one-cycle pulse)
//  o_mem_wr     out  1               RAM write select
//  o_mem_addr   out  ADDR_WIDTH      RAM word address = PADDR[ADDR_WIDTH+OFS-1:OFS]
//  o_mem_wdata  out  DATA_WIDTH      RAM write data
//  i_mem_rdata  in   DATA_WIDTH      RAM read data (valid cycle after enable w/ wr=0)
// BEHAVIOUR
//  Reset (async, i_rst=1): state IDLE; o_pready, o_pslverr, o_mem_en, o_mem_wr = 0; o_mem_addr, o_mem_wdata, o_prdata = 0.
//  All outputs registered except o_prdata (= i_mem_rdata in RD_DATA, else 0).
//  States: IDLE, WR, RD_ISSUE, RD_DATA, ERR (+ RMW_RD, RMW_MERGE, RMW_WR with macro).
//  IDLE: on i_psel=1 & i_penable=0 (setup, cycle T0) latch addr/data/dir, decode:
//   - error if PADDR[APB_ADDR_WIDTH-1:ADDR_WIDTH+OFS]!=0 or PADDR[OFS-1:0]!=0 -> ERR
//   - write -> WR; read -> RD_ISSUE; i_psel=1 & i_penable=1 in IDLE (no setup): ignored.
//  WR (T1): o_mem_en=1,o_mem_wr=1, addr/wdata driven; o_pready=1; RAM commits at end of T1 -> IDLE. 0 wait states.
//  RD_ISSUE (T1): o_mem_en=1,o_mem_wr=0; o_pready=0 -> RD_DATA.
//  RD_DATA (T2): o_pready=1, o_prdata=i_mem_rdata -> IDLE. Reads: 1 wait state.
//  ERR (T1): o_pready=1, o_pslverr=1, no RAM strobe -> IDLE. o_pslverr=0 in all other states.
//  o_mem_en high for exactly one cycle per RAM access; never high in IDLE or ERR.
//  Back-to-back: next setup phase seen in IDLE cycle after completion; no extra bubble.
//  i_psel deasserted in any non-IDLE state: abort to IDLE next cycle, o_pready=0; strobes already
//   issued are not revoked, no further RAM cycles for that transfer.
//  Reset mid-transfer: outputs to reset values immediately; interrupted transfer is lost, no response.
// CONFIGURATION
//  APB_MEM_PSTRB_EN defined: i_pstrb port present; write decode:
//   - pstrb all ones -> WR (as above); pstrb all zeros -> WR with o_mem_en=0 (pready T1, RAM untouched)
//   - partial -> RMW_RD (T1: read strobe, pready=0) -> RMW_MERGE (T2: merge i_mem_rdata with wdata
//     per byte, pready=0) -> RMW_WR (T3: write strobe, pready=1) -> IDLE. i_pstrb ignored on reads.
//  Not defined: no i_pstrb port, no RMW states; every write is full-word WR.
// TESTING
//  1 Write 0xDEADBEEF @0x0000_0010 -> T1: mem_en=1,wr=1,addr=0x0004,pready=1; read back -> pready T2, prdata=0xDEADBEEF.
//  2 Read @0x0004_0000 (out of range) and @0x0000_0011 (misaligned) -> T1: pready=1,pslverr=1, mem_en=0 throughout.
//  3 Write @0x10 then setup of read @0x10 in next cycle -> no bubble; read returns the written value.
//  4 MACRO on: RAM[4]=0x11223344, write 0xAABBCCDD pstrb=4'b0101 -> pready T3, RAM[4]=0x11BB33DD; pstrb=0 -> RAM unchanged, pready T1.
//  5 MACRO off: same write -> RAM[4]=0xAABBCCDD, pready T1.
//  6 i_rst=1 during RD_ISSUE -> all outputs 0 same cycle; after release, write/read @0x20 completes normally.

Source files
------------

// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: APB3 slave in front of a single-port synchronous RAM.
// The RAM has a 1-cycle registered read and commits writes on the clock edge.
// Writes complete with 0 wait states. Reads complete with 1 wait state.
// Decode errors respond with PSLVERR and never touch the RAM.
// Optional feature macro APB_MEM_PSTRB_EN adds the i_pstrb port. With it:
//   - an all-ones strobe is a plain write;
//   - an all-zeros strobe completes without any RAM access;
//   - a partial strobe runs a read-modify-write sequence.
//
// APB handshake: a transfer starts with a setup cycle (psel=1, penable=0)
// seen in IDLE. The access phase ends in the cycle where o_pready=1.
// The master must keep psel asserted until then. If psel drops before
// o_pready, the transfer is abandoned with no response.
// o_dbg_state exposes the FSM state for checkers.
module apb_mem_ctrl #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_psel,
  input  logic                      i_penable,
  input  logic                      i_pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0]     i_pwdata,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
`endif
  output logic [DATA_WIDTH-1:0]     o_prdata,
  output logic                      o_pready,
  output logic                      o_pslverr,
  output logic                      o_mem_en,
  output logic                      o_mem_wr,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
  output logic [2:0]                o_dbg_state
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(NB);
  localparam int HI_LSB = ADDR_WIDTH + OFS;
  localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK = APB_ADDR_WIDTH'((1 << OFS) - 1);

`ifdef APB_MEM_PSTRB_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR        = 3'd1,
    S_RD_ISSUE  = 3'd2,
    S_RD_DATA   = 3'd3,
    S_ERR       = 3'd4,
    S_RMW_RD    = 3'd5,
    S_RMW_MERGE = 3'd6,
    S_RMW_WR    = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DATA  = 3'd3,
    S_ERR      = 3'd4
  } state_t;
`endif

  state_t state_q, state_d;

  logic                  setup;
  logic                  accept;
  logic                  addr_err;
  logic                  wr_active;
  logic                  pready_d, pslverr_d, mem_en_d, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;

`ifdef APB_MEM_PSTRB_EN
  logic [NB-1:0]         pstrb_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  strb_partial;
`endif

  // Setup-phase detection and address decode.
  // Upper address bits beyond the RAM must be zero.
  // The byte offset inside a word must also be zero.
  always_comb begin
    setup    = i_psel & ~i_penable;
    accept   = setup & (state_q == S_IDLE);
    addr_err = (|(i_paddr >> HI_LSB)) | (|(i_paddr & ALIGN_MASK));
  end

`ifdef APB_MEM_PSTRB_EN
  // Strobe classification: an empty strobe skips the RAM, a partial one needs RMW.
  always_comb begin
    wr_active    = |i_pstrb;
    strb_partial = (|i_pstrb) & ~(&i_pstrb);
  end

  // Byte merge for RMW: enabled bytes from the write data, the rest from RAM.
  always_comb begin
    merged = o_mem_wdata;
    for (int b = 0; b < NB; b++) begin
      if (!pstrb_q[b]) merged[8*b +: 8] = i_mem_rdata[8*b +: 8];
    end
  end

  // Byte strobes captured at setup and used during the merge cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       pstrb_q <= '0;
    else if (accept) pstrb_q <= i_pstrb;
  end
`else
  // Without byte strobes every write is a full-word RAM write.
  always_comb begin
    wr_active = 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // Every non-IDLE state returns to IDLE when psel drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          if (addr_err)       state_d = S_ERR;
          else if (!i_pwrite) state_d = S_RD_ISSUE;
`ifdef APB_MEM_PSTRB_EN
          else if (strb_partial) state_d = S_RMW_RD;
`endif
          else                state_d = S_WR;
        end
      end
      S_WR:        state_d = S_IDLE;
      S_RD_ISSUE:  state_d = i_psel ? S_RD_DATA : S_IDLE;
      S_RD_DATA:   state_d = S_IDLE;
      S_ERR:       state_d = S_IDLE;
`ifdef APB_MEM_PSTRB_EN
      S_RMW_RD:    state_d = i_psel ? S_RMW_MERGE : S_IDLE;
      S_RMW_MERGE: state_d = i_psel ? S_RMW_WR : S_IDLE;
      S_RMW_WR:    state_d = S_IDLE;
`endif
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state.
  // The outputs are registered, so their values appear in the cycle that state is occupied.
  always_comb begin
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = o_mem_addr;
    mem_wdata_d = o_mem_wdata;
    case (state_d)
      S_WR: begin
        // WR is only entered from IDLE, so i_pstrb is still the setup-phase value.
        pready_d = 1'b1;
        mem_en_d = wr_active;
        mem_wr_d = wr_active;
      end
      S_RD_ISSUE: mem_en_d = 1'b1;
      S_RD_DATA:  pready_d = 1'b1;
      S_ERR: begin
        pready_d  = 1'b1;
        pslverr_d = 1'b1;
      end
`ifdef APB_MEM_PSTRB_EN
      S_RMW_RD: mem_en_d = 1'b1;
      S_RMW_WR: begin
        pready_d = 1'b1;
        mem_en_d = 1'b1;
        mem_wr_d = 1'b1;
      end
`endif
      default: ;
    endcase
    if (accept && !addr_err) begin
      mem_addr_d = i_paddr[HI_LSB-1:OFS];
      if (i_pwrite) mem_wdata_d = i_pwdata;
    end
`ifdef APB_MEM_PSTRB_EN
    if (state_q == S_RMW_MERGE) mem_wdata_d = merged;
`endif
  end

  // Registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pready    <= 1'b0;
      o_pslverr   <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_pready    <= pready_d;
      o_pslverr   <= pslverr_d;
      o_mem_en    <= mem_en_d;
      o_mem_wr    <= mem_wr_d;
      o_mem_addr  <= mem_addr_d;
      o_mem_wdata <= mem_wdata_d;
    end
  end

  // Read data passes straight from the RAM during the data cycle only.
  always_comb begin
    o_prdata    = (state_q == S_RD_DATA) ? i_mem_rdata : '0;
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Testbench for apb_mem_ctrl.
// It contains a behavioural RAM and an APB master task.
// A reference model predicts the expected response of each transfer.
module tb_apb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
`ifdef APB_MEM_PSTRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_bad    = 0;
  int en_cnt   = 0;
  int cyc      = 0;
  int xfer_start, xfer_done;
  logic [15:0] last_addr;
  logic        last_wr;

  logic [31:0] ram [0:65535];
  logic [31:0] ref_mem [int];

  apb_mem_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_psel      (psel),
    .i_penable   (penable),
    .i_pwrite    (pwrite),
    .i_paddr     (paddr),
    .i_pwdata    (pwdata),
`ifdef APB_MEM_PSTRB_EN
    .i_pstrb     (pstrb),
`endif
    .o_prdata    (prdata),
    .o_pready    (pready),
    .o_pslverr   (pslverr),
    .o_mem_en    (mem_en),
    .o_mem_wr    (mem_wr),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_dbg_state (dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc++;

  // Single-port RAM: registered read, write on the clock edge.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // RAM strobe monitor.
  always @(negedge clk) begin
    if (mem_en) begin
      en_cnt++;
      last_addr = mem_addr;
      last_wr   = mem_wr;
    end
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  // Reference model of one transfer, computed from the address map and strobe rules.
  // It updates ref_mem as a side effect.
  function automatic void model_xfer(input logic wr, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] strb,
                                     output logic e, output int w,
                                     output logic [31:0] rd, output int ens);
    int idx;
    logic [31:0] old;
    e   = (addr >= 32'h0004_0000) || (addr % 4 != 0);
    w   = 0;
    rd  = 32'h0;
    ens = 0;
    if (e) return;
    idx = int'(addr / 4);
    old = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (!wr) begin
      w   = 1;
      rd  = old;
      ens = 1;
    end else begin
`ifdef APB_MEM_PSTRB_EN
      if (strb == 4'hF) begin
        ens = 1;
        ref_mem[idx] = wdata;
      end else if (strb != 4'h0) begin
        w   = 2;
        ens = 2;
        for (int b = 0; b < 4; b++)
          if (strb[b]) old[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[idx] = old;
      end
`else
      ens = 1;
      ref_mem[idx] = wdata;
`endif
    end
  endfunction

  // One complete APB transfer.
  // The task leaves psel/penable high after the transfer, so a following call runs back-to-back.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rd, output logic err,
                          output int waits, output int ens);
    int  en0;
    bit  done;
    @(negedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
`ifdef APB_MEM_PSTRB_EN
    pstrb = strb;
`else
    if (strb != 4'hF) ;
`endif
    en0 = en_cnt;
    xfer_start = cyc;
    @(negedge clk); #1;
    penable = 1'b1;
    waits = 0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      if (pready) done = 1'b1;
      else begin
        waits++;
        @(negedge clk); #1;
      end
    end
    if (!done) check("pready_timeout", 1, 0);
    xfer_done = cyc;
    rd    = prdata;
    err   = pslverr;
    ens   = en_cnt - en0;
  endtask

  task automatic go_idle();
    @(negedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Transfer plus full comparison against the reference model.
  task automatic xfer_chk(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] rd, e_rd;
    logic        er, e_er;
    int          wt, e_wt, en, e_en;
    model_xfer(wr, addr, wdata, strb, e_er, e_wt, e_rd, e_en);
    apb_xfer(wr, addr, wdata, strb, rd, er, wt, en);
    check({tag, "_err"},   er, e_er);
    check({tag, "_waits"}, wt, e_wt);
    check({tag, "_rdata"}, rd, e_rd);
    check({tag, "_ens"},   en, e_en);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          waits;
    logic [31:0] rdata;
    int          ens;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd, e_rd, d;
    logic        er, e_er, w;
    logic [31:0] a;
    int          wt, en, e_wt, e_en;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 0, 32'h0,         1};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1, 32'hDEAD_BEEF, 1};
    vecs[2] = '{1'b0, 32'h0004_0000, 32'h0,         1'b1, 0, 32'h0,         0};
    vecs[3] = '{1'b0, 32'h0000_0011, 32'h0,         1'b1, 0, 32'h0,         0};
    vecs[4] = '{1'b1, 32'h0000_0012, 32'h1234_5678, 1'b1, 0, 32'h0,         0};
    vecs[5] = '{1'b1, 32'h0003_FFFC, 32'h0123_4567, 1'b0, 0, 32'h0,         1};
    vecs[6] = '{1'b0, 32'h0003_FFFC, 32'h0,         1'b0, 1, 32'h0123_4567, 1};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'h5555_5555, 1'b1, 0, 32'h0,         0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_MEM_PSTRB_EN
    pstrb = 4'hF;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_pready",  pready,    0);
    check("rst_pslverr", pslverr,   0);
    check("rst_mem_en",  mem_en,    0);
    check("rst_mem_wr",  mem_wr,    0);
    check("rst_addr",    mem_addr,  0);
    check("rst_wdata",   mem_wdata, 0);
    check("rst_prdata",  prdata,    0);
    check("rst_state",   dbg_state, 0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, e_er, e_wt, e_rd, e_en);
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'hF, rd, er, wt, en);
      check($sformatf("vec%0d_err", i),   er, vecs[i].err);
      check($sformatf("vec%0d_waits", i), wt, vecs[i].waits);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("vec%0d_ens", i),   en, vecs[i].ens);
      if (!vecs[i].err) begin
        check($sformatf("vec%0d_mem_addr", i), last_addr, vecs[i].addr[17:2]);
        check($sformatf("vec%0d_mem_wr", i),   last_wr,   vecs[i].wr);
      end
      go_idle();
    end

    // Back-to-back write then read with no bubble.
    xfer_chk("b2b_wr", 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
    a = xfer_start;
    xfer_chk("b2b_rd", 1'b0, 32'h10, 32'h0, 4'hF);
    check("b2b_cycles", xfer_done - a, 4);
    go_idle();

    // Abort: psel drops in RD_ISSUE.
    @(negedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(negedge clk); #1;
    penable = 1'b1;
    check("abort_t1_en",     mem_en, 1);
    check("abort_t1_pready", pready, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); #1;
    check("abort_t2_pready", pready, 0);
    check("abort_t2_en",     mem_en, 0);
    check("abort_t2_prdata", prdata, 0);
    xfer_chk("abort_after", 1'b0, 32'h10, 32'h0, 4'hF);
    go_idle();

    // Reset during RD_ISSUE.
    @(negedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(negedge clk); #1;
    penable = 1'b1;
    check("rstmid_en_before", mem_en, 1);
    rst = 1'b1;
    #1;
    check("rstmid_pready", pready,    0);
    check("rstmid_en",     mem_en,    0);
    check("rstmid_addr",   mem_addr,  0);
    check("rstmid_prdata", prdata,    0);
    check("rstmid_state",  dbg_state, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    xfer_chk("rstmid_wr", 1'b1, 32'h20, 32'h5A5A_A5A5, 4'hF);
    xfer_chk("rstmid_rd", 1'b0, 32'h20, 32'h0, 4'hF);
    go_idle();

    // Byte-strobe handling for the word at RAM[4].
    xfer_chk("strb_init", 1'b1, 32'h10, 32'h1122_3344, 4'hF);
`ifdef APB_MEM_PSTRB_EN
    apb_xfer(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, rd, er, wt, en);
    check("rmw_waits", wt, 2);
    check("rmw_ens",   en, 2);
    ref_mem[4] = 32'h11BB_33DD;
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt, en);
    check("rmw_rdback", rd, 32'h11BB_33DD);
    apb_xfer(1'b1, 32'h10, 32'h9999_9999, 4'h0, rd, er, wt, en);
    check("nostrb_waits", wt, 0);
    check("nostrb_ens",   en, 0);
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt, en);
    check("nostrb_rdback", rd, 32'h11BB_33DD);
`else
    apb_xfer(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, rd, er, wt, en);
    check("full_waits", wt, 0);
    check("full_ens",   en, 1);
    ref_mem[4] = 32'hAABB_CCDD;
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt, en);
    check("full_rdback", rd, 32'hAABB_CCDD);
`endif
    go_idle();

    // Randomised traffic over a small word pool, starting from known contents.
    for (int k = 0; k < 8; k++)
      xfer_chk("pool_init", 1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF);
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      d = $urandom;
      case ($urandom_range(0, 9))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = a | (32'h1 << $urandom_range(18, 31));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) go_idle();
      xfer_chk("rand", w, a, d, 4'($urandom_range(0, 15)));
    end
    go_idle();
    repeat (2) @(negedge clk);

    // Final RAM contents against the model.
    foreach (ref_mem[k]) check($sformatf("ram_final_%0d", k), ram[k], ref_mem[k]);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
